// File: rtl/rlbp_scan_ctrl_if.sv
// Signal bundle for rlbp_scan_ctrl.
//   Control : enable, frame_req, n_frames[7:0], center_idx[3:0], settle_cyc[3:0]
//   Analog  : pd_sel_a[11:0], pd_sel_b[11:0] one-hot photodiode selects
//   Timing  : tim_start (to counter), tim_clr / cmp_valid / cmp (from counter)
//   FIFO    : fifo_pop, code_o[7:0], fifo_empty, fifo_full, fifo_cnt[2:0]
//   Status  : busy, frame_done, ovf, tmo, err_clr
// The scan controller connects through the slave modport; whatever drives it
// (control logic, timing counter, reader) uses the master modport.
interface rlbp_scan_ctrl_if;
  logic        enable;
  logic        frame_req;
  logic [7:0]  n_frames;
  logic [3:0]  center_idx;
  logic [3:0]  settle_cyc;
  logic [11:0] pd_sel_a;
  logic [11:0] pd_sel_b;
  logic        tim_start;
  logic        tim_clr;
  logic        cmp_valid;
  logic        cmp;
  logic        fifo_pop;
  logic [7:0]  code_o;
  logic        fifo_empty;
  logic        fifo_full;
  logic [2:0]  fifo_cnt;
  logic        busy;
  logic        frame_done;
  logic        ovf;
  logic        tmo;
  logic        err_clr;

  modport slave (
    input  enable, frame_req, n_frames, center_idx, settle_cyc,
    input  tim_clr, cmp_valid, cmp, fifo_pop, err_clr,
    output pd_sel_a, pd_sel_b, tim_start, code_o, fifo_empty, fifo_full, fifo_cnt,
    output busy, frame_done, ovf, tmo
  );

  modport master (
    output enable, frame_req, n_frames, center_idx, settle_cyc,
    output tim_clr, cmp_valid, cmp, fifo_pop, err_clr,
    input  pd_sel_a, pd_sel_b, tim_start, code_o, fifo_empty, fifo_full, fifo_cnt,
    input  busy, frame_done, ovf, tmo
  );
endinterface

// File: rtl/rlbp_scan_ctrl.sv
// Ring-LBP scan controller. For each frame it runs eight comparator conversions,
// pairing the center photodiode with neighbours center+1..center+8 (mod 12),
// assembles the eight results MSB-first into a code and stores it in a 4-deep
// first-word-fall-through FIFO. Finite (n_frames>0) or continuous scans.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : rlbp_scan_ctrl_if.slave (control, photodiode selects, timing
//           counter handshake, FIFO read side, status flags)
module rlbp_scan_ctrl (
  input logic             clk,
  input logic             rst_n,
  rlbp_scan_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StRun, StWaitClr, StPush} state_e;

  // Timeout fires on the edge where the count would reach 4095.
  localparam logic [11:0] WdogLast = 12'd4094;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  frame_q, frame_d;
  logic [11:0] wdog_q, wdog_d;
  logic [3:0]  settle_q, settle_d;
  logic        ovf_q, tmo_q;

  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  cnt_q;

  logic [3:0]  ctr;
  logic [4:0]  nb_sum;
  logic [3:0]  nb_idx;
  logic [7:0]  frame_inc;
  logic        last_frame;
  logic        settle_done;
  logic        fifo_full, fifo_empty;
  logic        pop_en, push_en;
  logic        push_req, done, tmo_set, ovf_set, clr_seen;

  // Out-of-range center indices alias to photodiode 0.
  assign ctr    = (bus.center_idx > 4'd11) ? 4'd0 : bus.center_idx;
  assign nb_sum = {1'b0, ctr} + {2'b00, k_q} + 5'd1;
  assign nb_idx = (nb_sum >= 5'd12) ? 4'(nb_sum - 5'd12) : nb_sum[3:0];

  assign frame_inc   = (frame_q == 8'hFF) ? 8'hFF : frame_q + 8'd1;
  assign last_frame  = (bus.n_frames != 8'd0) && (frame_inc >= bus.n_frames);
  // settle_cyc=0 still spends one cycle in SETUP.
  assign settle_done = ({1'b0, settle_q} + 5'd1) >= {1'b0, bus.settle_cyc};

  assign fifo_full  = (cnt_q == 3'd4);
  assign fifo_empty = (cnt_q == 3'd0);
  assign pop_en     = bus.fifo_pop && !fifo_empty;
  // A pop on a full FIFO frees the slot for the same-cycle push.
  assign push_en    = push_req && (!fifo_full || pop_en);
  assign ovf_set    = push_req && fifo_full && !pop_en;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shift_d  = shift_q;
    frame_d  = frame_q;
    wdog_d   = wdog_q;
    settle_d = settle_q;
    push_req = 1'b0;
    done     = 1'b0;
    tmo_set  = 1'b0;
    clr_seen = 1'b0;

    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (bus.frame_req && bus.enable) begin
          state_d  = StSetup;
          k_d      = '0;
          shift_d  = '0;
          frame_d  = '0;
          settle_d = '0;
        end
      end
      StSetup: begin
        settle_d = settle_q + 4'd1;
        if (settle_done) begin
          state_d = StRun;
          wdog_d  = '0;
        end
      end
      StRun, StWaitClr: begin
        wdog_d = wdog_q + 12'd1;
        // A tim_clr arriving with the sample in RUN counts as the clear.
        clr_seen = bus.tim_clr && ((state_q == StWaitClr) || bus.cmp_valid);
        if ((state_q == StRun) && bus.cmp_valid) begin
          shift_d = {shift_q[6:0], bus.cmp};
          state_d = StWaitClr;
        end
        if (clr_seen) begin
          settle_d = '0;
          if (k_q == 3'd7) begin
            state_d = StPush;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = StSetup;
          end
        end
        if (wdog_q == WdogLast) begin
          state_d = StIdle;
          tmo_set = 1'b1;
        end
      end
      StPush: begin
        push_req = 1'b1;
        frame_d  = frame_inc;
        if (last_frame) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          state_d  = StSetup;
          k_d      = '0;
          shift_d  = '0;
          settle_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything: no push, no completion, no timeout.
    if (!bus.enable && (state_q != StIdle)) begin
      state_d  = StIdle;
      push_req = 1'b0;
      done     = 1'b0;
      tmo_set  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      shift_q  <= '0;
      frame_q  <= '0;
      wdog_q   <= '0;
      settle_q <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      shift_q  <= shift_d;
      frame_q  <= frame_d;
      wdog_q   <= wdog_d;
      settle_q <= settle_d;
      // Clear wins over a same-cycle set.
      ovf_q    <= bus.err_clr ? 1'b0 : (ovf_q | ovf_set);
      tmo_q    <= bus.err_clr ? 1'b0 : (tmo_q | tmo_set);
      if (push_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 2'd1;
      unique case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; code_o is masked while empty.
  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr_q] <= shift_q;
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.tim_start  = (state_q == StRun) || (state_q == StWaitClr);
  assign bus.pd_sel_a   = bus.busy ? (12'd1 << ctr) : 12'd0;
  assign bus.pd_sel_b   = bus.busy ? (12'd1 << nb_idx) : 12'd0;
  assign bus.frame_done = done;
  assign bus.code_o     = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign bus.fifo_empty = fifo_empty;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_cnt   = cnt_q;
  assign bus.ovf        = ovf_q;
  assign bus.tmo        = tmo_q;

endmodule

// File: tb/tb_rlbp_scan_ctrl.sv
module tb_rlbp_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rlbp_scan_ctrl_if bus ();
  rlbp_scan_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [11:0] v);
    int r = -1;
    for (int i = 0; i < 12; i++) if (v[i]) r = (r == -1) ? i : 99;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  localparam int PIdle = 0, PSettle = 1, PSample = 2, PClear = 3, PStore = 4;
  int         m_phase = PIdle, m_conv = 0, m_frames = 0, m_spent = 0, m_wd = 0;
  bit         m_bits[$];
  logic [7:0] m_fifo[$];
  bit         m_ovf = 1'b0, m_tmo = 1'b0;

  function automatic logic [7:0] code_of();
    logic [7:0] c = 8'h00;
    foreach (m_bits[i]) if (m_bits[i]) c = c | (8'h80 >> i);
    return c;
  endfunction

  always @(posedge clk) begin : model_b
    bit full, pop_ok, ovf_set, tmo_set, clr;
    int need;
    if (!rst_n) begin
      m_phase = PIdle; m_conv = 0; m_frames = 0; m_spent = 0; m_wd = 0;
      m_bits.delete(); m_fifo.delete(); m_ovf = 1'b0; m_tmo = 1'b0;
    end else begin
      full    = (m_fifo.size() == 4);
      pop_ok  = bus.fifo_pop && (m_fifo.size() != 0);
      ovf_set = 1'b0;
      tmo_set = 1'b0;
      if (pop_ok) void'(m_fifo.pop_front());
      if (m_phase != PIdle && !bus.enable) begin
        m_phase = PIdle;
      end else begin
        case (m_phase)
          PIdle: if (bus.frame_req && bus.enable) begin
            m_phase = PSettle; m_conv = 0; m_frames = 0; m_spent = 0; m_bits.delete();
          end
          PSettle: begin
            m_spent++;
            need = (bus.settle_cyc == 0) ? 1 : int'(bus.settle_cyc);
            if (m_spent >= need) begin m_phase = PSample; m_wd = 0; end
          end
          PSample, PClear: begin
            m_wd++;
            clr = 1'b0;
            if (m_wd == 4095) begin
              m_phase = PIdle; tmo_set = 1'b1;
            end else begin
              if (m_phase == PSample) begin
                if (bus.cmp_valid) begin
                  m_bits.push_back(bus.cmp); m_phase = PClear; clr = bus.tim_clr;
                end
              end else clr = bus.tim_clr;
              if (clr) begin
                if (m_conv == 7) m_phase = PStore;
                else begin m_conv++; m_spent = 0; m_phase = PSettle; end
              end
            end
          end
          PStore: begin
            if (full && !pop_ok) ovf_set = 1'b1;
            else m_fifo.push_back(code_of());
            m_frames = (m_frames == 255) ? 255 : m_frames + 1;
            if (bus.n_frames != 0 && m_frames >= int'(bus.n_frames)) m_phase = PIdle;
            else begin m_phase = PSettle; m_conv = 0; m_spent = 0; m_bits.delete(); end
          end
          default: m_phase = PIdle;
        endcase
      end
      m_ovf = bus.err_clr ? 1'b0 : (m_ovf | ovf_set);
      m_tmo = bus.err_clr ? 1'b0 : (m_tmo | tmo_set);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin : cmp_b
      int c, nxt;
      bit e_busy, e_done;
      logic [11:0] ea, eb;
      c      = (bus.center_idx > 11) ? 0 : int'(bus.center_idx);
      e_busy = (m_phase != PIdle);
      ea     = e_busy ? (12'd1 << c) : 12'd0;
      eb     = e_busy ? (12'd1 << ((c + m_conv + 1) % 12)) : 12'd0;
      nxt    = (m_frames == 255) ? 255 : m_frames + 1;
      e_done = (m_phase == PStore) && bus.enable && (bus.n_frames != 0) &&
               (nxt >= int'(bus.n_frames));
      check("busy", bus.busy, e_busy);
      check("tim_start", bus.tim_start, (m_phase == PSample) || (m_phase == PClear));
      check("pd_sel_a", bus.pd_sel_a, ea);
      check("pd_sel_b", bus.pd_sel_b, eb);
      check("frame_done", bus.frame_done, e_done);
      check("fifo_cnt", bus.fifo_cnt, m_fifo.size());
      check("fifo_empty", bus.fifo_empty, m_fifo.size() == 0);
      check("fifo_full", bus.fifo_full, m_fifo.size() == 4);
      check("code_o", bus.code_o, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00);
      check("ovf", bus.ovf, m_ovf);
      check("tmo", bus.tmo, m_tmo);
    end
  end

  // ---------------- timing-counter responder ----------------
  bit resp_on = 1'b0;
  bit pat[$];
  int ts_cnt = 0, d_val = 1, d_clr = 1;
  always @(posedge clk) begin
    #1;
    bus.cmp_valid = 1'b0;
    bus.tim_clr   = 1'b0;
    if (resp_on && bus.tim_start) begin
      ts_cnt++;
      if (ts_cnt == d_val) begin
        bus.cmp_valid = 1'b1;
        if (pat.size() != 0) bus.cmp = pat.pop_front();
        else bus.cmp = 1'($urandom);
      end
      if (ts_cnt == d_clr) bus.tim_clr = 1'b1;
    end else begin
      ts_cnt = 0;
      d_val  = $urandom_range(1, 4);
      d_clr  = d_val + $urandom_range(0, 3);
    end
  end

  // ---------------- directed helpers ----------------
  int nb_seen[$];
  int a_first;
  int done_cnt;
  int exp1 [8] = '{6, 7, 8, 9, 10, 11, 0, 1};

  task automatic scan(input int budget);
    bit ts_prev = 1'b0;
    int i = 0;
    nb_seen.delete(); done_cnt = 0; a_first = -1;
    bus.frame_req = 1'b1; step(); bus.frame_req = 1'b0;
    while (bus.busy && i < budget) begin
      if (bus.tim_start && !ts_prev) begin
        nb_seen.push_back(oh_idx(bus.pd_sel_b));
        if (a_first < 0) a_first = oh_idx(bus.pd_sel_a);
      end
      if (bus.frame_done) done_cnt++;
      ts_prev = bus.tim_start;
      step(); i++;
    end
    check("scan_finished", bus.busy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && !bus.fifo_empty; i++) begin bus.fifo_pop = 1'b1; step(); end
    bus.fifo_pop = 1'b0;
    check("drained", bus.fifo_empty, 1'b1);
  endtask

  // Steps until n rising (rise=1) or falling edges of tim_start have been seen.
  task automatic wait_edges(input bit rise, input int n, input int budget);
    bit prev = bus.tim_start;
    int cnt = 0, i = 0;
    while (cnt < n && i < budget) begin
      step(); i++;
      if (rise ? (!prev && bus.tim_start) : (prev && !bus.tim_start)) cnt++;
      prev = bus.tim_start;
    end
    check("edges_reached", cnt, n);
  endtask

  task automatic start_and_wait_run();
    int i = 0;
    bus.frame_req = 1'b1; step(); bus.frame_req = 1'b0;
    while (!bus.tim_start && i < 40) begin step(); i++; end
    check("run_entered", bus.tim_start, 1'b1);
  endtask

  initial begin : watchdog_b
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "tb timeout");
  end

  initial begin : stim_b
    int cyc;
    bus.enable = 1'b0; bus.frame_req = 1'b0; bus.n_frames = 8'd1; bus.center_idx = 4'd0;
    bus.settle_cyc = 4'd0; bus.tim_clr = 1'b0; bus.cmp_valid = 1'b0; bus.cmp = 1'b0;
    bus.fifo_pop = 1'b0; bus.err_clr = 1'b0; rst_n = 1'b0;
    step(); chk_en = 1'b1; step(); step();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_empty", bus.fifo_empty, 1'b1);
    check("rst_full", bus.fifo_full, 1'b0);
    check("rst_cnt", bus.fifo_cnt, 3'd0);
    check("rst_code", bus.code_o, 8'h00);
    check("rst_flags", {bus.ovf, bus.tmo, bus.tim_start, bus.frame_done}, 4'b0000);
    check("rst_sel", {bus.pd_sel_a, bus.pd_sel_b}, 24'h0);
    rst_n = 1'b1; bus.enable = 1'b1; resp_on = 1'b1;

    // Reference frame: center 5, pattern 1,0,1,1,0,0,1,0 -> 0xB2.
    bus.center_idx = 4'd5; bus.n_frames = 8'd1; bus.settle_cyc = 4'd2;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    scan(400);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_code", bus.code_o, 8'hB2);
    check("t1_center", a_first, 5);
    check("t1_nb_count", nb_seen.size(), 8);
    for (int i = 0; i < 8; i++)
      check("t1_nb_seq", (i < nb_seen.size()) ? nb_seen[i] : -1, exp1[i]);
    drain();

    // Wrap-around neighbours and out-of-range center.
    bus.center_idx = 4'd11; bus.settle_cyc = 4'd0;
    scan(400);
    for (int i = 0; i < 8; i++)
      check("t2_nb_wrap", (i < nb_seen.size()) ? nb_seen[i] : -1, i);
    bus.center_idx = 4'd14;
    scan(400);
    check("t2_center14", a_first, 0);
    for (int i = 0; i < 8; i++)
      check("t2_nb_c14", (i < nb_seen.size()) ? nb_seen[i] : -1, i + 1);
    drain();

    // Continuous mode, no pops: fill, overflow, then pop together with a push.
    bus.n_frames = 8'd0; bus.center_idx = 4'd3; bus.settle_cyc = 4'd1;
    bus.frame_req = 1'b1; step(); bus.frame_req = 1'b0;
    cyc = 0;
    while (!bus.fifo_full && cyc < 2000) begin step(); cyc++; end
    check("t3_full", bus.fifo_full, 1'b1);
    check("t3_cnt4", bus.fifo_cnt, 3'd4);
    check("t3_no_ovf_yet", bus.ovf, 1'b0);
    cyc = 0;
    while (!bus.ovf && cyc < 1000) begin step(); cyc++; end
    check("t3_ovf", bus.ovf, 1'b1);
    check("t3_cnt_after_drop", bus.fifo_cnt, 3'd4);
    bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
    check("t3_ovf_cleared", bus.ovf, 1'b0);
    wait_edges(1'b0, 8, 600);
    bus.fifo_pop = 1'b1; step(); bus.fifo_pop = 1'b0;
    check("t3_pushpop_cnt", bus.fifo_cnt, 3'd4);
    check("t3_pushpop_ovf", bus.ovf, 1'b0);
    bus.enable = 1'b0; step(); bus.enable = 1'b1;
    check("t3_abort_idle", bus.busy, 1'b0);
    check("t3_fifo_kept", bus.fifo_cnt, 3'd4);
    drain();

    // Watchdog: withhold cmp_valid.
    resp_on = 1'b0; bus.n_frames = 8'd1; bus.settle_cyc = 4'd0;
    start_and_wait_run();
    cyc = 0;
    while (bus.tim_start && cyc < 5000) begin cyc++; step(); end
    check("t4_run_len", cyc, 4095);
    check("t4_tmo", bus.tmo, 1'b1);
    check("t4_idle", bus.busy, 1'b0);
    bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
    check("t4_tmo_cleared", bus.tmo, 1'b0);
    start_and_wait_run();
    cyc = 0;
    while (bus.tim_start && cyc < 5000) begin
      cyc++;
      if (cyc == 4095) bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
    end
    check("t4_run_len2", cyc, 4095);
    check("t4_clr_wins", bus.tmo, 1'b0);
    check("t4_idle2", bus.busy, 1'b0);
    resp_on = 1'b1;

    // Abort during conversion 3, then reset during PUSH.
    bus.settle_cyc = 4'd1;
    scan(400);
    check("t5_one_code", bus.fifo_cnt, 3'd1);
    bus.frame_req = 1'b1; step(); bus.frame_req = 1'b0;
    wait_edges(1'b1, 4, 400);
    bus.enable = 1'b0; step(); bus.enable = 1'b1;
    check("t5_abort_busy", bus.busy, 1'b0);
    check("t5_abort_tim", bus.tim_start, 1'b0);
    check("t5_abort_sel", {bus.pd_sel_a, bus.pd_sel_b}, 24'h0);
    check("t5_abort_cnt", bus.fifo_cnt, 3'd1);
    check("t5_abort_done", bus.frame_done, 1'b0);
    bus.frame_req = 1'b1; step(); bus.frame_req = 1'b0;
    wait_edges(1'b0, 8, 600);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("t5_rst_cnt", bus.fifo_cnt, 3'd0);
    check("t5_rst_busy", bus.busy, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      bus.fifo_pop  = ($urandom_range(0, 3) == 0);
      bus.err_clr   = ($urandom_range(0, 63) == 0);
      bus.enable    = ($urandom_range(0, 299) != 0);
      bus.frame_req = 1'b0;
      if (!bus.busy) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.center_idx = 4'($urandom);
          bus.settle_cyc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
          bus.n_frames   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
          bus.frame_req  = 1'b1;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        bus.frame_req = 1'b1;
      end
      step();
    end

    bus.enable = 1'b0; bus.fifo_pop = 1'b0; bus.frame_req = 1'b0; bus.err_clr = 1'b0;
    resp_on = 1'b0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rlbp_scan_ctrl.md
RLBP_SCAN_CTRL -- requirements
Module: rlbp_scan_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-003 enable  in  1  level; 1 = scanning permitted, 0 = abort to IDLE.
REQ-004 frame_req  in  1  pulse; starts a scan when in IDLE with enable=1.
REQ-005 n_frames  in  8  codes per scan; 0 = continuous.
REQ-006 center_idx  in  4  center photodiode index, legal 0..11; values 12..15 shall be treated as 0.
REQ-007 settle_cyc  in  4  settle cycles between selection change and timing start.
REQ-008 pd_sel_a  out  12  one-hot center selection (bit i drives Pd{i+1}_a).
REQ-009 pd_sel_b  out  12  one-hot neighbour selection (bit i drives Pd{i+1}_b).
REQ-010 tim_start  out  1  level start to the timing counter.
REQ-011 tim_clr  in  1  pulse from the timing counter at the end of a conversion cycle.
REQ-012 cmp_valid  in  1  sample strobe from the timing counter.
REQ-013 cmp  in  1  comparator result, valid when cmp_valid=1.
REQ-014 fifo_pop  in  1  read strobe; ignored when the FIFO is empty.
REQ-015 code_o  out  8  FIFO head, valid when fifo_empty=0.
REQ-016 fifo_empty / fifo_full  out  1 each  FIFO status flags.
REQ-017 fifo_cnt  out  3  FIFO occupancy, range 0..4.
REQ-018 busy  out  1  1 whenever state != IDLE.
REQ-019 frame_done  out  1  one-cycle pulse when a finite scan completes.
REQ-020 ovf / tmo  out  1 each  sticky overflow / timeout flags.
REQ-021 err_clr  in  1  clears ovf and tmo.

Function
REQ-022 States: IDLE, SETUP, RUN, WAIT_CLR, PUSH.
REQ-023 IDLE -> SETUP on frame_req=1 and enable=1; conversion index k=0, frame count=0, code shift register=0.
REQ-024 SETUP drives the selections:
  - pd_sel_a = onehot(center_idx).
  - pd_sel_b = onehot((center_idx+k+1) mod 12).
  - Holds settle_cyc cycles; settle_cyc=0 means exactly 1 cycle in SETUP; then -> RUN.
REQ-025 RUN holds tim_start=1 and waits for cmp_valid.
  - On cmp_valid: shift register <= {shift[6:0], cmp}, then -> WAIT_CLR.
REQ-026 WAIT_CLR holds tim_start=1 until tim_clr.
  - On tim_clr: tim_start drops the next cycle.
  - k=7 -> PUSH; otherwise k=k+1 -> SETUP.
REQ-027 If cmp_valid and tim_clr arrive in the same cycle while in RUN, the bit shall be captured and the block shall proceed as if WAIT_CLR had seen tim_clr.
REQ-028 PUSH takes one cycle:
  - Writes the code to the FIFO, or drops it and sets ovf if the FIFO is full with no simultaneous pop.
  - Increments frame count.
  - If n_frames=0, or frame count < n_frames: -> SETUP with k=0 and the shift register cleared.
  - Otherwise: -> IDLE with frame_done=1 for that cycle.
REQ-029 Bit order: conversion 0 lands in code bit 7, conversion 7 in bit 0.
REQ-030 Watchdog: a 12-bit counter clears on each entry to RUN and counts while in RUN/WAIT_CLR.
  - On reaching 4095 it sets tmo and forces IDLE.
  - The partial code is discarded.
REQ-031 enable=0 in any non-IDLE state forces IDLE on the next edge:
  - tim_start=0, pd_sel_a=pd_sel_b=0, partial code discarded, no frame_done.
  - FIFO contents are kept.
REQ-032 In IDLE: pd_sel_a=0, pd_sel_b=0, tim_start=0; frame_req while busy is ignored.
REQ-033 FIFO: 4 entries, first-word fall-through.
  - Simultaneous push and pop when full: both succeed, no ovf.
  - Simultaneous push and pop when empty: only the push takes effect.
  - Read and write pointers are 2-bit and wrap.
REQ-034 err_clr has priority over a same-cycle set of ovf/tmo (clear wins).
REQ-035 Frame count is 8-bit and shall not wrap in continuous mode: it saturates at 255.

Reset
REQ-036 rst_n=0 on a clock edge forces:
  - state IDLE, k=0, shift register 0, frame count 0, watchdog 0.
  - FIFO empty: fifo_cnt=0, fifo_empty=1, fifo_full=0, code_o=0.
  - pd_sel_a=0, pd_sel_b=0, tim_start=0, busy=0, frame_done=0, ovf=0, tmo=0.
REQ-037 Reset asserted mid-scan shall abort identically to REQ-036, with no partial push.

Verification
REQ-038 center_idx=5, n_frames=1, settle_cyc=2; cmp pattern 1,0,1,1,0,0,1,0 over 8 conversions.
  - pd_sel_b one-hot sequence shall be indices 6,7,8,9,10,11,0,1.
  - code_o=0xB2, frame_done one pulse, busy drops.
REQ-039 center_idx=11: neighbour sequence shall be 0..7 (wrap-around); center_idx=14 shall behave as center_idx=0.
REQ-040 n_frames=0 with no pops.
  - Four codes stored, fifo_full=1.
  - The 5th code is dropped and ovf=1.
  - The next pop in the same cycle as a push keeps fifo_cnt=4 and ovf unchanged.
REQ-041 cmp_valid withheld after entering RUN.
  - tmo=1 and the block returns to IDLE after 4095 cycles.
  - err_clr asserted in the same cycle as a new tmo set leaves tmo=0.
REQ-042 enable dropped during conversion 3.
  - Next cycle: IDLE, tim_start=0, pd_sel=0, fifo_cnt unchanged, no frame_done.
  - rst_n=0 during PUSH leaves fifo_cnt=0.
